// File: rtl/kb_digit_entry_pkg.sv
// Shared types, scan codes and decode helper for the PS/2 digit-entry block.
package kb_digit_entry_pkg;

  typedef enum logic [2:0] {
    S_WAIT = 3'd0,
    S_POP  = 3'd1,
    S_PROC = 3'd2,
    S_CONV = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_D0 = 8'h45, SC_D1 = 8'h16, SC_D2 = 8'h1E, SC_D3 = 8'h26, SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E, SC_D6 = 8'h36, SC_D7 = 8'h3D, SC_D8 = 8'h3E, SC_D9 = 8'h46;

  localparam logic [7:0] SC_KP0 = 8'h70, SC_KP1 = 8'h69, SC_KP2 = 8'h72, SC_KP3 = 8'h7A, SC_KP4 = 8'h6B;
  localparam logic [7:0] SC_KP5 = 8'h73, SC_KP6 = 8'h74, SC_KP7 = 8'h6C, SC_KP8 = 8'h75, SC_KP9 = 8'h7D;

  // Returns {is_digit, digit}; main-row and keypad digits decode identically.
  function automatic logic [4:0] scan_digit(input logic [7:0] code);
    case (code)
      SC_D0, SC_KP0: return {1'b1, 4'd0};
      SC_D1, SC_KP1: return {1'b1, 4'd1};
      SC_D2, SC_KP2: return {1'b1, 4'd2};
      SC_D3, SC_KP3: return {1'b1, 4'd3};
      SC_D4, SC_KP4: return {1'b1, 4'd4};
      SC_D5, SC_KP5: return {1'b1, 4'd5};
      SC_D6, SC_KP6: return {1'b1, 4'd6};
      SC_D7, SC_KP7: return {1'b1, 4'd7};
      SC_D8, SC_KP8: return {1'b1, 4'd8};
      SC_D9, SC_KP9: return {1'b1, 4'd9};
      default:       return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/kb_digit_entry_scan2digit.sv
// Combinational make-code classifier, reusable by any keyboard consumer.
module scan2digit
  import kb_digit_entry_pkg::*;
(
  input  logic [7:0] key_code,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_enter,
  output logic       is_bksp,
  output logic       is_esc
);

  always_comb begin
    {is_digit, digit} = scan_digit(key_code);
    is_enter = (key_code == SC_ENTER);
    is_bksp  = (key_code == SC_BKSP);
    is_esc   = (key_code == SC_ESC);
  end

endmodule

// File: rtl/kb_digit_entry.sv
// Assembles a decimal number from PS/2 make codes popped off the kb_code FIFO
// and commits it as a binary value with a one-cycle valid strobe.
module kb_digit_entry
  import kb_digit_entry_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int OUT_W      = 8,
  parameter int MAX_VALUE  = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      key_code,
  input  logic                            kb_buf_empty,
  output logic                            rd_key_code,
  output logic [OUT_W-1:0]                value,
  output logic                            value_valid,
  output logic                            err_tick,
  output logic [$clog2(MAX_DIGITS+1)-1:0] digit_cnt,
  output logic [4*MAX_DIGITS-1:0]         entry_bcd,
  output logic                            busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int BUF_W = 4 * MAX_DIGITS;
  localparam int ACC_W = OUT_W + 4;

  state_e             state_q, state_d;
  logic [7:0]         code_q, code_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   value_q, value_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic               is_digit, is_enter, is_bksp, is_esc;
  logic [3:0]         digit;
  logic [3:0]         conv_digit;
  logic [ACC_W-1:0]   step;

  scan2digit u_scan2digit (
    .key_code (code_q),
    .is_digit (is_digit),
    .digit    (digit),
    .is_enter (is_enter),
    .is_bksp  (is_bksp),
    .is_esc   (is_esc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT;
      code_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (!kb_buf_empty) state_d = S_POP;
      S_POP:   state_d = S_PROC;
      S_PROC:  state_d = (is_enter && cnt_q != '0) ? S_CONV : S_WAIT;
      S_CONV:  if (idx_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    rd_key_code = (state_q == S_POP);
    busy        = (state_q != S_WAIT);
  end

  // Conversion walks the buffer oldest digit first, i.e. from the highest nibble down.
  always_comb begin
    conv_digit = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (idx_q == CNT_W'(i)) conv_digit = buf_q[4*i +: 4];
    end
    step = acc_q * ACC_W'(10) + ACC_W'(conv_digit);
  end

  // Accumulator never exceeds MAX_VALUE, so the OUT_W+4 bit step cannot wrap.
  always_comb begin
    code_d  = code_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    value_d = value_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_WAIT: if (!kb_buf_empty) code_d = key_code;
      S_PROC: begin
        if (is_digit) begin
          if (cnt_q < CNT_W'(MAX_DIGITS)) begin
            buf_d = BUF_W'({buf_q, digit});
            cnt_d = cnt_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_bksp) begin
          if (cnt_q != '0) begin
            buf_d = buf_q >> 4;
            cnt_d = cnt_q - 1'b1;
          end
        end else if (is_esc) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (is_enter) begin
          if (cnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            acc_d = '0;
            ovf_d = 1'b0;
            idx_d = cnt_q - 1'b1;
          end
        end
      end
      S_CONV: begin
        if (step > ACC_W'(MAX_VALUE)) ovf_d = 1'b1;
        else                          acc_d = step;
        if (idx_q == '0) begin
          if (!ovf_d) begin
            value_d = acc_d[OUT_W-1:0];
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: begin
        buf_d = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign err_tick    = err_q;
  assign digit_cnt   = cnt_q;
  assign entry_bcd   = buf_q;

endmodule

// File: tb/tb_kb_digit_entry.sv
// Directed bench: a queue models the kb_code FIFO, key sequences come from a vector table.
module tb_kb_digit_entry;

  localparam int MAX_DIGITS = 3;
  localparam int OUT_W      = 8;
  localparam int MAX_VALUE  = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  key_code = 8'h00;
  logic        kb_buf_empty = 1'b1;
  logic        rd_key_code;
  logic [7:0]  value;
  logic        value_valid;
  logic        err_tick;
  logic [1:0]  digit_cnt;
  logic [11:0] entry_bcd;
  logic        busy;

  always #5 clk = ~clk;

  kb_digit_entry #(
    .MAX_DIGITS (MAX_DIGITS),
    .OUT_W      (OUT_W),
    .MAX_VALUE  (MAX_VALUE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_code     (key_code),
    .kb_buf_empty (kb_buf_empty),
    .rd_key_code  (rd_key_code),
    .value        (value),
    .value_valid  (value_valid),
    .err_tick     (err_tick),
    .digit_cnt    (digit_cnt),
    .entry_bcd    (entry_bcd),
    .busy         (busy)
  );

  typedef struct {
    logic [63:0] keys;
    int          nkeys;
    int          exp_value;
    int          exp_valid;
    int          exp_err;
    int          exp_cnt;
    int          exp_bcd;
    int          exp_lat;
  } vec_t;

  vec_t       vecs [16];
  logic [7:0] fifo [$];
  int cyc = 0;
  int pops = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int enter_cyc = -1;
  int latency = -1;
  int compared = 0;
  int mismatched = 0;

  always @(posedge clk) cyc++;

  // FIFO model and pulse monitors, all sampled on the falling edge.
  always @(negedge clk) begin
    logic [7:0] popped;
    if (rd_key_code && fifo.size() > 0) begin
      popped = fifo.pop_front();
      pops++;
      if (popped == 8'h5A) enter_cyc = cyc;
    end
    if (value_valid) begin
      valid_cnt++;
      latency = cyc - enter_cyc;
    end
    if (err_tick) err_cnt++;
    if (value_valid && err_tick) both_cnt++;
    kb_buf_empty = (fifo.size() == 0);
    key_code     = (fifo.size() == 0) ? 8'h00 : fifo[0];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      #1;
      if (fifo.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idle_timeout: got busy=%0d fifo=%0d, expected idle", busy, fifo.size());
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [63:0] keys, input int n);
    for (int i = 0; i < n; i++) fifo.push_back(keys[i*8 +: 8]);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_pops, base_valid, base_err, old_enter;
    bit found;

    vecs[0]  = '{64'h5A_26_16,             3,  13, 1, 0, 0, 12'h000,  4};
    vecs[1]  = '{64'h5A_36_2E_1E,          4,  13, 0, 1, 0, 12'h000, -1};
    vecs[2]  = '{64'h25_26_1E_16,          4,  13, 0, 1, 3, 12'h123, -1};
    vecs[3]  = '{64'h5A,                   1, 123, 1, 0, 0, 12'h000,  5};
    vecs[4]  = '{64'h5A_25_66_46,          4,   4, 1, 0, 0, 12'h000,  3};
    vecs[5]  = '{64'h66,                   1,   4, 0, 0, 0, 12'h000, -1};
    vecs[6]  = '{64'h5A,                   1,   4, 0, 1, 0, 12'h000, -1};
    vecs[7]  = '{64'h5A_76_3D,             3,   4, 0, 1, 0, 12'h000, -1};
    vecs[8]  = '{64'h1C,                   1,   4, 0, 0, 0, 12'h000, -1};
    vecs[9]  = '{64'h5A_45,                2,   0, 1, 0, 0, 12'h000,  3};
    vecs[10] = '{64'h5A_6C_70_70,          4,   7, 1, 0, 0, 12'h000,  5};
    vecs[11] = '{64'h5A_73_73_72,          4, 255, 1, 0, 0, 12'h000,  5};
    vecs[12] = '{64'h5A_1E_1C_25,          4,  42, 1, 0, 0, 12'h000,  4};
    vecs[13] = '{64'h5A_1C_46_66_25_26_1E_16, 8, 129, 1, 1, 0, 12'h000, 5};
    vecs[14] = '{64'h69_7D,                2, 129, 0, 0, 2, 12'h091, -1};
    vecs[15] = '{64'h76,                   1, 129, 0, 0, 0, 12'h000, -1};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_output("rst value",       32'(value),       0);
    check_output("rst value_valid", 32'(value_valid), 0);
    check_output("rst err_tick",    32'(err_tick),    0);
    check_output("rst digit_cnt",   32'(digit_cnt),   0);
    check_output("rst entry_bcd",   32'(entry_bcd),   0);
    check_output("rst busy",        32'(busy),        0);
    check_output("rst rd_key_code", 32'(rd_key_code), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    for (int i = 0; i < 16; i++) begin
      base_pops  = pops;
      base_valid = valid_cnt;
      base_err   = err_cnt;
      apply_stimulus(vecs[i].keys, vecs[i].nkeys);
      check_output($sformatf("v%0d value", i),     32'(value),            vecs[i].exp_value);
      check_output($sformatf("v%0d valid_n", i),   valid_cnt - base_valid, vecs[i].exp_valid);
      check_output($sformatf("v%0d err_n", i),     err_cnt - base_err,     vecs[i].exp_err);
      check_output($sformatf("v%0d digit_cnt", i), 32'(digit_cnt),        vecs[i].exp_cnt);
      check_output($sformatf("v%0d entry_bcd", i), 32'(entry_bcd),        vecs[i].exp_bcd);
      check_output($sformatf("v%0d pops", i),      pops - base_pops,       vecs[i].nkeys);
      if (vecs[i].exp_lat >= 0)
        check_output($sformatf("v%0d latency", i), latency, vecs[i].exp_lat);
    end

    // Reset in the first conversion cycle; queued keys must survive and be read afterwards.
    old_enter = enter_cyc;
    found = 1'b0;
    fifo.push_back(8'h16);
    fifo.push_back(8'h1E);
    fifo.push_back(8'h26);
    fifo.push_back(8'h5A);
    fifo.push_back(8'h2E);
    fifo.push_back(8'h5A);
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      #1;
      if (enter_cyc != old_enter && cyc == enter_cyc + 2) found = 1'b1;
    end
    check_output("conv reached", 32'(found), 1);
    check_output("conv busy", 32'(busy), 1);
    check_output("conv digit_cnt", 32'(digit_cnt), 3);
    reset = 1'b0;
    #1;
    check_output("midrst value",       32'(value),       0);
    check_output("midrst value_valid", 32'(value_valid), 0);
    check_output("midrst err_tick",    32'(err_tick),    0);
    check_output("midrst digit_cnt",   32'(digit_cnt),   0);
    check_output("midrst entry_bcd",   32'(entry_bcd),   0);
    check_output("midrst busy",        32'(busy),        0);
    check_output("midrst rd_key_code", 32'(rd_key_code), 0);
    check_output("midrst fifo left",   fifo.size(),      2);
    @(negedge clk);
    base_pops  = pops;
    base_valid = valid_cnt;
    reset = 1'b1;
    wait_idle();
    check_output("post value",   32'(value),             5);
    check_output("post valid_n", valid_cnt - base_valid, 1);
    check_output("post pops",    pops - base_pops,       2);
    check_output("post latency", latency,                3);

    check_output("valid_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
